// File: rtl/ln_series_unit.sv
// ln(1+x) for unsigned fixed-point x: normalise 1+x to 2^k*m with m in [0.75,1.5),
// run an N_TERMS Maclaurin series on u=m-1, then add k*ln2 and round to the output format.
module ln_series_unit #(
  parameter int IN_W     = 18,
  parameter int IN_FRAC  = 16,
  parameter int OUT_W    = 18,
  parameter int OUT_FRAC = 16,
  parameter int N_TERMS  = 16,
  parameter int GUARD    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IN_W-1:0]  xBus,
  output logic [OUT_W-1:0] rBus,
  output logic             busy,
  output logic             done
);

  localparam int F   = OUT_FRAC + GUARD;
  localparam int IW  = IN_W - IN_FRAC;
  localparam int YW  = IW + 1 + F;
  localparam int W   = F + 4;
  localparam int KW  = $clog2(IW + 2);
  localparam int NW  = $clog2(N_TERMS + 1);
  localparam int SW0 = F + KW + 4;
  localparam int SW  = (SW0 > OUT_W + 2) ? SW0 : OUT_W + 2;

  localparam logic        [YW-1:0] ONE_Y  = {{(YW-F-1){1'b0}}, 1'b1, {F{1'b0}}};
  localparam logic        [YW-1:0] THRESH = {{(YW-F-1){1'b0}}, 2'b11, {(F-1){1'b0}}};
  localparam logic signed [W-1:0]  ONE_W  = {{(W-F-1){1'b0}}, 1'b1, {F{1'b0}}};
  localparam int                   LN2_F  = $rtoi(0.6931471805599453 * (2.0 ** F) + 0.5);
  localparam logic signed [SW-1:0] LN2_S  = SW'(LN2_F);
  localparam logic signed [SW-1:0] HALF   = SW'((2 ** GUARD) / 2);

  function automatic logic [(N_TERMS+1)*W-1:0] build_recip();
    logic [(N_TERMS+1)*W-1:0] t;
    longint num;
    t = '0;
    for (int n = 1; n <= N_TERMS; n++) begin
      num = ((longint'(1) << (F + 1)) + longint'(n)) / (2 * longint'(n));
      t[n*W +: W] = W'(num);
    end
    return t;
  endfunction

  localparam logic [(N_TERMS+1)*W-1:0] RECIP_TBL = build_recip();

  function automatic logic [YW-1:0] to_y(input logic [IN_W-1:0] x);
    return YW'(x) << (F - IN_FRAC);
  endfunction

  function automatic logic signed [SW-1:0] round_guard(input logic signed [SW-1:0] v);
    return (v + HALF) >>> GUARD;
  endfunction

  function automatic logic [OUT_W-1:0] sat_out(input logic signed [SW-1:0] v);
    if (v[SW-1])
      return '0;
    else if (|v[SW-2:OUT_W])
      return '1;
    else
      return v[OUT_W-1:0];
  endfunction

  typedef enum logic [2:0] {IDLE, NORM, SERIES, SCALE, DONE} state_t;

  state_t                 state_q, state_d;
  logic [YW-1:0]          y_q, y_d;
  logic [KW-1:0]          k_q, k_d;
  logic signed [W-1:0]    u_q, u_d;
  logic signed [W-1:0]    pow_q, pow_d;
  logic signed [W-1:0]    acc_q, acc_d;
  logic [NW-1:0]          n_q, n_d;
  logic [OUT_W-1:0]       res_q, res_d;
  logic [OUT_W-1:0]       rbus_q, rbus_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic signed [2*W-1:0]  prod_pu, prod_t;
  logic signed [W-1:0]    pow_next, recip_n, term;
  logic signed [SW-1:0]   res_full;

  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    k_d     = k_q;
    u_d     = u_q;
    pow_d   = pow_q;
    acc_d   = acc_q;
    n_d     = n_q;
    res_d   = res_q;
    rbus_d  = rbus_q;
    busy_d  = (state_q != IDLE);
    done_d  = (state_q == DONE);

    // Products floor to F fraction bits by keeping the arithmetic-shifted slice.
    prod_pu  = pow_q * u_q;
    pow_next = W'(prod_pu >>> F);
    recip_n  = RECIP_TBL[W*int'(n_q) +: W];
    prod_t   = pow_next * recip_n;
    term     = W'(prod_t >>> F);
    res_full = SW'(acc_q) + SW'($signed({1'b0, k_q})) * LN2_S;

    case (state_q)
      IDLE: begin
        if (start) begin
          y_d     = to_y(xBus) + ONE_Y;
          k_d     = '0;
          pow_d   = ONE_W;
          acc_d   = '0;
          n_d     = NW'(1);
          state_d = NORM;
        end
      end
      NORM: begin
        if (y_q >= THRESH) begin
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          u_d     = $signed(W'(y_q[F:0])) - ONE_W;
          state_d = SERIES;
        end
      end
      SERIES: begin
        pow_d = pow_next;
        acc_d = n_q[0] ? acc_q + term : acc_q - term;
        if (n_q == NW'(N_TERMS))
          state_d = SCALE;
        else
          n_d = n_q + NW'(1);
      end
      SCALE: begin
        res_d   = sat_out(round_guard(res_full));
        state_d = DONE;
      end
      DONE: begin
        rbus_d  = res_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      y_q     <= '0;
      k_q     <= '0;
      u_q     <= '0;
      pow_q   <= '0;
      acc_q   <= '0;
      n_q     <= '0;
      res_q   <= '0;
      rbus_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      k_q     <= k_d;
      u_q     <= u_d;
      pow_q   <= pow_d;
      acc_q   <= acc_d;
      n_q     <= n_d;
      res_q   <= res_d;
      rbus_q  <= rbus_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign rBus = rbus_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
